ram32x4_arbiter: RTL and testbench
==================================

# ram32x4_arbiter

Two-port front end for a 32-word × 4-bit single-port RAM, giving two independent requesters (e.g. switch-driven user port and a display scanner) shared, round-robin access with a req/gnt handshake. Also contains a sequenced clear engine that zero-fills the whole array on command. Sits between the board-level top (switches/keys/hex decoders) and the RAM storage.

## Interface
- ADDR_W, 5, word address width (depth = 2**ADDR_W = 32)
- DATA_W, 4, data word width
- clk  in  1  system clock, all logic rising-edge
- resetn  in  1  synchronous, active-low reset (sampled on rising clk)
- req0 / req1  in  1  access request, held until granted
- we0 / we1  in  1  1 = write, 0 = read; valid while req high
- addr0 / addr1  in  ADDR_W  access address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  combinational grant; access is committed at the clk edge where gnt is high
- rvalid0 / rvalid1  out  1  registered, one-cycle pulse: read data for that port on rdata
- rdata  out  DATA_W  shared read-data bus, meaningful only with an rvalid
- clear_start  in  1  pulse: request zero-fill of all 32 words
- busy  out  1  high while clear engine owns the RAM
- clear_done  out  1  one-cycle pulse after last clear write

## Operation
- States: IDLE, CLEAR. Reset -> IDLE; last-grant pointer = 1 (so port 0 wins first tie); clear_pending = 0.
- All outputs 0 in reset. RAM contents not reset.
- IDLE, per cycle: at most one grant. Only req0 -> gnt0; only req1 -> gnt1; both -> grant port not granted last; update pointer on every grant. No req -> no grant, pointer unchanged.
- gnt depends only on current req inputs, state, pointer, clear_pending; never on we/addr/wdata.
- clear_start in IDLE sets clear_pending. If clear_pending is set at a cycle start, no grant that cycle; enter CLEAR next cycle with clear address = 0.
- CLEAR: write 0 to address 0..31, one per cycle (32 cycles), busy = 1, no grants. After writing 31: clear_done = 1 for one cycle, return to IDLE, clear_pending = 0.
- clear_start while clear_pending or CLEAR: ignored.
- Write grant: mem[addr] <= wdata at that edge; no rvalid.
- Read grant: rvalid<port> = 1 the next cycle, rdata = mem[addr] as of after the same edge's writes. (Only one access per edge, so no same-cycle collision.)
- rdata holds its last value when no rvalid; reset value 0.

## Timing
- Grant-to-write-committed: 0 cycles (the granting edge).
- Grant-to-rvalid: 1 cycle. Sustained throughput 1 access/cycle.
- Write at edge N, read of same address granted at edge N+1 -> returns new data at N+2.
- Both ports requesting continuously: grants alternate 0,1,0,1…; neither port waits >1 cycle.
- clear_start at edge N in IDLE: cycle N+1 no grant, edges N+2..N+33 CLEAR writes, clear_done high in cycle after edge N+33, first grant possible same cycle as clear_done deasserts -> cycle N+35.
- resetn low mid-CLEAR: abort at next edge; IDLE, busy = 0, no clear_done; words already cleared stay 0, rest unchanged.
- resetn low cycle following a read grant: rvalid suppressed (0).

## Structure
- Shared package: ADDR_W/DATA_W defaults, state encoding (IDLE, CLEAR), RAM_DEPTH = 32.
- Sub-module ram32x4_core: synchronous-write, asynchronous-read 32×4 array (addr, wdata, we, clk, rdata); arbiter registers read data itself.
- Arbiter: mux/pointer logic, 5-bit clear counter, FSM, rvalid/rdata registers.

## Test plan
- Reset then req0 write addr 5 data 0xA, then req1 read addr 5 -> gnt0, next cycle gnt1, rvalid1 one cycle later with rdata = 0xA, rvalid0 never high.
- req0 and req1 both held high 6 cycles, reads of addr 1/2 -> gnt sequence 0,1,0,1,0,1; rvalid alternates with rdata matching preloaded words.
- Write addr 31 = 0xF from port 1, read addr 31 from port 0 next cycle -> rdata 0xF, rvalid0 exactly 2 cycles after the write grant.
- Fill all 32 words with 0x7, pulse clear_start with req0 held -> busy for 32 cycles, no gnt0 throughout, clear_done one cycle, then gnt0; read back all 32 addresses = 0x0.
- clear_start repeated during CLEAR -> single clear_done, total CLEAR length still 32 cycles.
- resetn low at clear cycle 10 -> busy 0 next cycle, no clear_done; addrs 0–9 read 0x0, addrs 10–31 keep 0x7.

Source files
------------

// File: rtl/ram32x4_arbiter_pkg.sv
// Shared constants and state encoding for the 32x4 RAM front end.
package ram32x4_arbiter_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 4;
  localparam int RAM_DEPTH  = 2 ** DEF_ADDR_W;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/ram32x4_core.sv
// Storage array: synchronous write, asynchronous read.
module ram32x4_core
  import ram32x4_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/ram32x4_arbiter.sv
// Round-robin two-port front end with a sequenced zero-fill engine.
module ram32x4_arbiter
  import ram32x4_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  input  logic              clear_start,
  output logic              busy,
  output logic              clear_done
);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              pending_q, pending_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  ram32x4_core #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_core (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      pending_q  <= 1'b0;
      done_q     <= 1'b0;
      clr_addr_q <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      pending_q  <= pending_d;
      done_q     <= done_d;
      clr_addr_q <= clr_addr_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata_q    <= rdata_d;
    end
  end

  // pending stays set through the clear_done cycle so no grant or new clear can slip in
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    done_d     = 1'b0;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (done_q) begin
          pending_d = 1'b0;
        end else if (pending_q) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end else if (clear_start) begin
          pending_d = 1'b1;
        end
      end
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == '1) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (resetn && state_q == ST_IDLE && !pending_q) begin
      if (req0 && (!req1 || last_q)) gnt0 = 1'b1;
      else if (req1)                 gnt1 = 1'b1;
    end

    ram_we    = 1'b0;
    ram_addr  = addr0;
    ram_wdata = wdata0;
    if (state_q == ST_CLEAR) begin
      ram_we    = resetn;
      ram_addr  = clr_addr_q;
      ram_wdata = '0;
    end else if (gnt0) begin
      ram_we = we0;
    end else if (gnt1) begin
      ram_we    = we1;
      ram_addr  = addr1;
      ram_wdata = wdata1;
    end

    last_d    = gnt0 ? 1'b0 : (gnt1 ? 1'b1 : last_q);
    rvalid0_d = gnt0 && !we0;
    rvalid1_d = gnt1 && !we1;
    rdata_d   = (rvalid0_d || rvalid1_d) ? ram_rdata : rdata_q;

    busy       = resetn && state_q == ST_CLEAR;
    clear_done = resetn && done_q;
    rvalid0    = resetn && rvalid0_q;
    rvalid1    = resetn && rvalid1_q;
    rdata      = rdata_q;
  end

endmodule

// File: tb/tb_ram32x4_arbiter.sv
// Randomized bench for ram32x4_arbiter against a cycle-level behavioural model.
module tb_ram32x4_arbiter;
  import ram32x4_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  resetn, req0, req1, we0, we1, clear_start;
  logic [DEF_ADDR_W-1:0] addr0, addr1;
  logic [DEF_DATA_W-1:0] wdata0, wdata1;
  logic                  gnt0, gnt1, rvalid0, rvalid1, busy, clear_done;
  logic [DEF_DATA_W-1:0] rdata;

  int checks = 0;
  int failures = 0;

  ram32x4_arbiter dut (
    .clk(clk), .resetn(resetn),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .clear_start(clear_start), .busy(busy), .clear_done(clear_done)
  );

  // Behavioural model: memory image plus a few flags describing the clear sequence.
  logic [DEF_DATA_W-1:0] m_mem [RAM_DEPTH];
  int   m_last = 1;
  bit   m_pending = 0, m_clearing = 0, m_done = 0, m_rv0 = 0, m_rv1 = 0;
  int   m_clear_idx = 0;
  logic [DEF_DATA_W-1:0] m_rdata = '0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_grant();
    if (!resetn || m_pending || m_clearing || m_done) return -1;
    if (req0 && req1) return 1 - m_last;
    if (req0) return 0;
    if (req1) return 1;
    return -1;
  endfunction

  task automatic model_edge(input int g);
    if (!resetn) begin
      m_pending = 0; m_clearing = 0; m_done = 0;
      m_last = 1; m_rv0 = 0; m_rv1 = 0; m_rdata = '0;
      return;
    end
    m_rv0 = 0; m_rv1 = 0;
    if (g == 0) begin
      if (we0) m_mem[addr0] = wdata0;
      else begin m_rv0 = 1; m_rdata = m_mem[addr0]; end
      m_last = 0;
    end else if (g == 1) begin
      if (we1) m_mem[addr1] = wdata1;
      else begin m_rv1 = 1; m_rdata = m_mem[addr1]; end
      m_last = 1;
    end
    if (m_done) m_done = 0;
    else if (m_clearing) begin
      m_mem[m_clear_idx] = '0;
      m_clear_idx++;
      if (m_clear_idx == RAM_DEPTH) begin
        m_clearing = 0; m_done = 1; m_pending = 0;
      end
    end else if (m_pending) begin
      m_clearing = 1; m_clear_idx = 0;
    end else if (clear_start) m_pending = 1;
  endtask

  task automatic run_cycle();
    int g;
    #2;
    g = exp_grant();
    checkOutput("gnt0", gnt0, g == 0);
    checkOutput("gnt1", gnt1, g == 1);
    checkOutput("busy", busy, resetn && m_clearing);
    checkOutput("clear_done", clear_done, resetn && m_done);
    checkOutput("rvalid0", rvalid0, resetn && m_rv0);
    checkOutput("rvalid1", rvalid1, resetn && m_rv1);
    if (resetn && (m_rv0 || m_rv1)) checkOutput("rdata", rdata, m_rdata);
    @(posedge clk);
    model_edge(g);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input bit r0, input bit w0, input logic [4:0] a0, input logic [3:0] d0,
                               input bit r1, input bit w1, input logic [4:0] a1, input logic [3:0] d1,
                               input bit cs, input bit rn);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    clear_start = cs; resetn = rn;
    run_cycle();
  endtask

  task automatic idle(input bit cs);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, cs, 1);
  endtask

  task automatic fill_all(input logic [3:0] d);
    for (int a = 0; a < RAM_DEPTH; a++) applyStimulus(1, 1, 5'(a), d, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    int busy_cnt, done_cnt, bad_gnt, k;
    resetn = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; clear_start = 0;
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 3, 0, 1, 0, 4, 0, 1, 0);
    checkOutput("reset_rdata", rdata, 0);
    checkOutput("reset_busy", busy, 0);
    idle(0);

    // Preload random data, alternating writer ports.
    for (int a = 0; a < RAM_DEPTH; a++) begin
      if (a % 2 == 0) applyStimulus(1, 1, 5'(a), 4'($urandom), 0, 0, 0, 0, 0, 1);
      else            applyStimulus(0, 0, 0, 0, 1, 1, 5'(a), 4'($urandom), 0, 1);
    end

    applyStimulus(1, 1, 5, 4'hA, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 5, 0, 0, 1);
    checkOutput("tp1_rdata", rdata, 4'hA);
    idle(0);

    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 1, 0, 1, 0, 2, 0, 0, 1);
    idle(0);

    applyStimulus(0, 0, 0, 0, 1, 1, 31, 4'hF, 0, 1);
    applyStimulus(1, 0, 31, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("tp3_rdata", rdata, 4'hF);
    checkOutput("tp3_rvalid0", rvalid0, 1);
    idle(0);

    // Full clear with req0 held; then with repeated clear_start pulses.
    for (int pass = 0; pass < 2; pass++) begin
      fill_all(4'h7);
      busy_cnt = 0; done_cnt = 0; bad_gnt = 0;
      for (int i = 0; i < 40; i++) begin
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0,
                      i == 0 || (pass == 1 && (i == 5 || i == 20 || i == 33)), 1);
        busy_cnt += int'(busy);
        done_cnt += int'(clear_done);
        if ((busy || clear_done) && gnt0) bad_gnt++;
      end
      checkOutput("clear_busy_cycles", busy_cnt, 32);
      checkOutput("clear_done_pulses", done_cnt, 1);
      checkOutput("clear_no_gnt", bad_gnt, 0);
      for (int a = 0; a < RAM_DEPTH; a++) begin
        applyStimulus(1, 0, 5'(a), 0, 0, 0, 0, 0, 0, 1);
        checkOutput("clear_readback", rdata, 0);
      end
    end

    // Reset during clear cycle 10 aborts the sequence.
    fill_all(4'h7);
    idle(1);
    k = 0;
    while (!(m_clearing && m_clear_idx == 10) && k < 20) begin idle(0); k++; end
    checkOutput("abort_reached", k < 20, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("abort_busy", busy, 0);
    done_cnt = 0;
    for (int a = 0; a < RAM_DEPTH; a++) begin
      applyStimulus(0, 0, 0, 0, 1, 0, 5'(a), 0, 0, 1);
      done_cnt += int'(clear_done);
      checkOutput("abort_readback", rdata, (a < 10) ? 0 : 7);
    end
    checkOutput("abort_no_done", done_cnt, 0);

    for (int i = 0; i < 400; i++)
      applyStimulus($urandom, $urandom, 5'($urandom), 4'($urandom),
                    $urandom, $urandom, 5'($urandom), 4'($urandom),
                    $urandom_range(0, 39) == 0, $urandom_range(0, 79) != 0);
    idle(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
